// File: rtl/seg_scan_mux.sv
// Time-multiplexed hex digit scanner: tear-free shadow register, one-hot digit
// drive with a dark gap at the start of every slot, optional leading-zero blanking.
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      lz_blank,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      update,
  output logic [3:0]                hex,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      blank,
  output logic                      frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_SCAN = 1'b1;

  logic                    state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] stage;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    pending;

  logic                    slot_end;
  logic                    at_boundary;
  logic                    scanning;
  logic                    lit;
  logic                    tail_zero;
  logic [NUM_DIGITS-1:0]   lz_hit;
  logic [3:0]              nib [NUM_DIGITS];

  assign scanning    = (state == STATE_SCAN);
  assign slot_end    = (cnt == CNT_W'(SCAN_DIV - 1));
  assign at_boundary = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= STATE_IDLE;
      cnt     <= '0;
      idx     <= '0;
      // NOTE: stage/shadow are data registers but are reset explicitly, so the
      // display restarts showing zeros rather than whatever was held before.
      stage   <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      case (state)
        STATE_IDLE: begin
          // Not scanning, so nothing can tear: load straight into the shadow.
          if (update) begin
            shadow  <= value;
            pending <= 1'b0;
          end else if (enable && pending) begin
            shadow  <= stage;
            pending <= 1'b0;
          end
          if (enable) begin
            state <= STATE_SCAN;
            cnt   <= '0;
            idx   <= '0;
          end
        end

        default: begin
          // Shadow only moves on the frame boundary; a coincident update wins
          // over the older staged value.
          if (at_boundary) begin
            if (update) begin
              shadow <= value;
            end else if (pending) begin
              shadow <= stage;
            end
            pending <= 1'b0;
          end else if (update) begin
            stage   <= value;
            pending <= 1'b1;
          end

          if (!enable) begin
            state <= STATE_IDLE;
            cnt   <= '0;
            idx   <= '0;
          end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    tail_zero = 1'b1;
    lz_hit    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib[k]    = shadow[4*k +: 4];
      tail_zero = tail_zero && (nib[k] == 4'h0);
      lz_hit[k] = tail_zero && (k != 0);
    end
  end

  assign lit = scanning && (cnt >= CNT_W'(BLANK_CYCLES)) && !(lz_blank && lz_hit[idx]);

  always_comb begin
    digit_en = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit_en[k] = lit && (idx == IDX_W'(k));
    end
  end

  assign hex        = scanning ? nib[idx] : 4'h0;
  assign blank      = ~|digit_en;
  assign frame_done = scanning && at_boundary;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: directed scenarios plus random traffic,
// all compared against a frame-position reference model.
module tb_seg_scan_mux;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        lz_blank;
  logic [15:0] value;
  logic        update;
  logic [3:0]  hex;
  logic [3:0]  digit_en;
  logic        blank;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] dut_outs;
  assign dut_outs = {hex, digit_en, blank, frame_done};

  seg_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lz_blank(lz_blank),
    .value(value), .update(update), .hex(hex), .digit_en(digit_en),
    .blank(blank), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: position within the frame plus the value on display.
  logic        m_scan;
  int          m_pos;
  logic [15:0] m_shown;
  logic        m_pend;
  logic [15:0] m_pend_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_scan <= 1'b0; m_pos <= 0; m_shown <= '0; m_pend <= 1'b0; m_pend_val <= '0;
    end else if (!m_scan) begin
      if (update) begin
        m_shown <= value; m_pend <= 1'b0;
      end else if (enable && m_pend) begin
        m_shown <= m_pend_val; m_pend <= 1'b0;
      end
      if (enable) begin
        m_scan <= 1'b1; m_pos <= 0;
      end
    end else begin
      if (m_pos == FRAME - 1) begin
        if (update) m_shown <= value;
        else if (m_pend) m_shown <= m_pend_val;
        m_pend <= 1'b0;
      end else if (update) begin
        m_pend <= 1'b1; m_pend_val <= value;
      end
      if (!enable) begin
        m_scan <= 1'b0; m_pos <= 0;
      end else begin
        m_pos <= (m_pos + 1) % FRAME;
      end
    end
  end

  function automatic logic [9:0] model_outs();
    int         slot;
    int         cyc;
    logic [3:0] h;
    logic [3:0] e;
    logic       lzb;
    if (!m_scan) return {4'h0, 4'h0, 1'b1, 1'b0};
    slot = m_pos / SD;
    cyc  = m_pos % SD;
    h    = 4'((m_shown >> (4 * slot)) & 16'hF);
    lzb  = lz_blank && (slot >= 1) && ((m_shown >> (4 * slot)) == 16'h0);
    e    = (cyc >= BC && !lzb) ? 4'(1 << slot) : 4'h0;
    return {h, e, (e == 4'h0), (m_pos == FRAME - 1)};
  endfunction

  function automatic logic [3:0] nib_of(input logic [15:0] v, input int slot);
    return 4'((v >> (4 * slot)) & 16'hF);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic restart_with(input logic [15:0] v);
    enable = 1'b0; update = 1'b0; tick();
    update = 1'b1; value = v;     tick();
    update = 1'b0; enable = 1'b1; tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; lz_blank = 1'b0; update = 1'b0; value = '0;
    tick(); tick();
    n_checks++;
    if (dut_outs !== 10'b0000_0000_1_0) begin
      n_fail++; $display("FAIL reset_outs got %b expected %b", dut_outs, 10'b0000_0000_1_0);
    end
    rst_n = 1'b1; tick();
    n_checks++;
    if (dut_outs !== model_outs()) begin
      n_fail++; $display("FAIL reset_idle got %b expected %b", dut_outs, model_outs());
    end
  endtask

  task automatic test_basic();
    logic [9:0] exp;
    logic [3:0] e;
    restart_with(16'h1234);
    for (int i = 0; i < FRAME; i++) begin
      e   = ((i % SD) >= BC) ? 4'(1 << (i / SD)) : 4'h0;
      exp = {4'(4 - i / SD), e, (e == 4'h0), (i == FRAME - 1)};
      n_checks++;
      if (dut_outs !== exp) begin
        n_fail++; $display("FAIL basic cyc=%0d got %b expected %b", i, dut_outs, exp);
      end
      n_checks++;
      if (dut_outs !== model_outs()) begin
        n_fail++; $display("FAIL basic_model cyc=%0d got %b expected %b", i, dut_outs, model_outs());
      end
      tick();
    end
  endtask

  task automatic test_lz();
    logic [9:0] exp;
    logic [3:0] e;
    lz_blank = 1'b1;
    restart_with(16'h0050);
    for (int i = 0; i < FRAME; i++) begin
      e   = ((i % SD) >= BC && (i / SD) <= 1) ? 4'(1 << (i / SD)) : 4'h0;
      exp = {nib_of(16'h0050, i / SD), e, (e == 4'h0), (i == FRAME - 1)};
      n_checks++;
      if (dut_outs !== exp) begin
        n_fail++; $display("FAIL lz_0050 cyc=%0d got %b expected %b", i, dut_outs, exp);
      end
      tick();
    end
    restart_with(16'h0000);
    for (int i = 0; i < FRAME; i++) begin
      e   = ((i % SD) >= BC && (i / SD) == 0) ? 4'h1 : 4'h0;
      exp = {4'h0, e, (e == 4'h0), (i == FRAME - 1)};
      n_checks++;
      if (dut_outs !== exp) begin
        n_fail++; $display("FAIL lz_0000 cyc=%0d got %b expected %b", i, dut_outs, exp);
      end
      tick();
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_midframe_update();
    logic [3:0] exp_hex;
    restart_with(16'h1234);
    for (int i = 0; i < 2 * FRAME; i++) begin
      exp_hex = nib_of((i < FRAME) ? 16'h1234 : 16'hABCD, (i % FRAME) / SD);
      n_checks++;
      if (hex !== exp_hex) begin
        n_fail++; $display("FAIL midframe_hex cyc=%0d got %h expected %h", i, hex, exp_hex);
      end
      n_checks++;
      if (dut_outs !== model_outs()) begin
        n_fail++; $display("FAIL midframe_model cyc=%0d got %b expected %b", i, dut_outs, model_outs());
      end
      if (i == 8) begin update = 1'b1; value = 16'hABCD; end
      if (i == 9) update = 1'b0;
      tick();
    end
  endtask

  task automatic test_boundary_update();
    logic [3:0] exp_hex;
    for (int i = 0; i < 2 * FRAME; i++) begin
      exp_hex = nib_of((i < FRAME) ? 16'hABCD : 16'h5678, (i % FRAME) / SD);
      n_checks++;
      if (hex !== exp_hex) begin
        n_fail++; $display("FAIL boundary_hex cyc=%0d got %h expected %h", i, hex, exp_hex);
      end
      if (i == 3)  begin update = 1'b1; value = 16'h9999; end
      if (i == 4)  update = 1'b0;
      if (i == 31) begin update = 1'b1; value = 16'h5678; end
      if (i == 32) update = 1'b0;
      tick();
    end
  endtask

  task automatic test_disable();
    for (int i = 0; i <= 20; i++) begin
      n_checks++;
      if (dut_outs !== model_outs()) begin
        n_fail++; $display("FAIL disable_pre cyc=%0d got %b expected %b", i, dut_outs, model_outs());
      end
      if (i == 20) enable = 1'b0;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dut_outs !== 10'b0000_0000_1_0) begin
        n_fail++; $display("FAIL disable_idle cyc=%0d got %b expected %b", i, dut_outs, 10'b0000_0000_1_0);
      end
      tick();
    end
    enable = 1'b1; tick();
    n_checks++;
    if (dut_outs !== {4'h8, 4'h0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL reenable_cyc0 got %b expected %b", dut_outs, {4'h8, 4'h0, 1'b1, 1'b0});
    end
    tick(); tick();
    n_checks++;
    if (dut_outs !== {4'h8, 4'h1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reenable_cyc2 got %b expected %b", dut_outs, {4'h8, 4'h1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_outs !== 10'b0000_0000_1_0) begin
      n_fail++; $display("FAIL async_reset got %b expected %b", dut_outs, 10'b0000_0000_1_0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < FRAME; i++) begin
      n_checks++;
      if (hex !== 4'h0 || dut_outs !== model_outs()) begin
        n_fail++; $display("FAIL after_reset cyc=%0d got %b expected %b", i, dut_outs, model_outs());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      n_checks++;
      if (dut_outs !== model_outs()) begin
        n_fail++; $display("FAIL random cyc=%0d got %b expected %b", i, dut_outs, model_outs());
      end
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
      update = ($urandom_range(0, 7) == 0);
      value  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      tick();
    end
    update = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_midframe_update();
    test_boundary_update();
    test_disable();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
